blockd_out_fifo: RTL

Elastic buffer directly downstream of blockD's outD ready/valid source. It decouples blockD from the consumer, absorbing back-pressure bursts with a DEPTH-entry first-word-fall-through FIFO. It exports occupancy and an almost-full flag for flow monitoring by the blockD status path.

---
 rtl/blockd_out_fifo.sv | 101 ++++++++++
 1 files changed

// File: rtl/blockd_out_fifo.sv
// blockd_out_fifo: first-word-fall-through elastic buffer behind blockD outD.
// The buffer holds DEPTH beats. It reports occupancy (count) and a registered
// almost_full flag to the blockD status path.
// Optional feature: define BLOCKD_OUT_FIFO_HWM_EN to add the high-water-mark
// register (hwm) and its synchronous clear (hwm_clr).
module blockd_out_fifo #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = 6,
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  count,
`ifdef BLOCKD_OUT_FIFO_HWM_EN
   output logic [CNT_W-1:0]  hwm,
   input  logic              hwm_clr,
`endif
   output logic              almost_full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_THRESH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wp;
   logic [PTR_W-1:0]  rp;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              af_q;
   logic              push;
   logic              pop;

   // Handshakes depend only on registered count, so there is no in->out or
   // out_rdy->in_rdy combinational path.
   assign in_rdy      = (cnt_q != FULL_C);
   assign out_vld     = (cnt_q != '0);
   assign push        = in_vld & in_rdy;
   assign pop         = out_vld & out_rdy;
   assign out_data    = mem[rp];
   assign count       = cnt_q;
   assign almost_full = af_q;

   // Next occupancy: +1 on push only, -1 on pop only, else hold
   always_comb begin
      cnt_nxt = cnt_q;
      case ({push, pop})
         2'b10:   cnt_nxt = cnt_q + CNT_W'(1);
         2'b01:   cnt_nxt = cnt_q - CNT_W'(1);
         default: cnt_nxt = cnt_q;
      endcase
   end

   // Storage array write; contents are intentionally not reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wp] <= in_data;
      end
   end

   // Pointers, occupancy and almost_full (taken from next count so the flag
   // tracks count exactly)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp    <= '0;
         rp    <= '0;
         cnt_q <= '0;
         af_q  <= 1'b0;
      end else begin
         if (push) begin
            wp <= wp + PTR_W'(1);
         end
         if (pop) begin
            rp <= rp + PTR_W'(1);
         end
         cnt_q <= cnt_nxt;
         af_q  <= (cnt_nxt >= AF_C);
      end
   end

`ifdef BLOCKD_OUT_FIFO_HWM_EN
   // High-water mark of next count; clear reloads it and wins over the max
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hwm <= '0;
      end else if (hwm_clr) begin
         hwm <= cnt_nxt;
      end else if (cnt_nxt > hwm) begin
         hwm <= cnt_nxt;
      end
   end
`endif

endmodule
